// File: rtl/fp16_pkg.sv
// Shared binary16/binary32 field definitions for the half-to-single stream
// converter. Configuration macro: HALF2SINGLE_SUBNORM_EN (subnormal normalization).
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  // Difference between the binary32 bias (127) and the binary16 bias (15)
  localparam logic [7:0] FP_BIAS_DELTA = 8'd112;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORM,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] frac;
  } fp32_t;

  // Classify a binary16 value from its exponent and mantissa fields
  function automatic fp_class_t fp16_classify(input fp16_t h);
    fp_class_t c;
    if (h.exp == '0) begin
      c = (h.man == '0) ? ZERO : SUBNORM;
    end else if (h.exp == '1) begin
      c = (h.man == '0) ? INF : NAN;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/lzc10.sv
// Combinational leading-zero counter for the 10-bit binary16 mantissa.
// Returns 10 for an all-zero input (never consumed by the converter).
module lzc10 (
  input  logic [9:0] din,
  output logic [3:0] lz
);

  // Scan upward so the highest set bit is the last one to write lz
  always_comb begin
    lz = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (din[i]) begin
        lz = 4'(9 - i);
      end
    end
  end

endmodule

// File: rtl/half2single_stream.sv
// Two-stage stall-able binary16 -> binary32 converter with valid/ready
// handshake and saturating subnormal/NaN statistics counters.
// Configuration macro: HALF2SINGLE_SUBNORM_EN -- when defined, subnormals are
// normalized using lzc10; when undefined they flush to signed zero.
module half2single_stream
  import fp16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_subnorm,
  output logic [CNT_W-1:0] cnt_nan
);

  fp16_t     in_h;
  fp_class_t in_cls;
  logic      advance;
  logic      accept;

  // Stage 1 state
  logic      s1_valid_q, s1_valid_d;
  logic      sign_q, sign_d;
  fp_class_t cls_q, cls_d;
  logic [FP16_EXP_W-1:0] exp_q, exp_d;
  logic [FP16_MAN_W-1:0] man_q, man_d;

  // Stage 2 state
  logic      out_valid_q, out_valid_d;
  fp32_t     out_data_q, out_data_d;
  fp32_t     assembled;

  // Statistics state
  logic [CNT_W-1:0] cnt_sub_q, cnt_sub_d;
  logic [CNT_W-1:0] cnt_nan_q, cnt_nan_d;

  assign in_h    = in_data;
  assign in_cls  = fp16_classify(in_h);
  assign advance = ~out_valid_q | out_ready;
  assign accept  = in_valid & advance;

  assign in_ready    = advance;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign cnt_subnorm = cnt_sub_q;
  assign cnt_nan     = cnt_nan_q;

`ifdef HALF2SINGLE_SUBNORM_EN
  logic [3:0] in_lz;
  logic [3:0] lz_q, lz_d;
  logic [9:0] sub_frac;
  logic [7:0] sub_exp;

  lzc10 u_lzc10 (
    .din (in_h.man),
    .lz  (in_lz)
  );

  // Leading-zero count rides along with stage 1 when the pipe advances
  always_comb begin
    lz_d = lz_q;
    if (advance) begin
      lz_d = in_lz;
    end
  end

  // Shift the leading one out of the mantissa and rebias the exponent
  always_comb begin
    sub_frac = man_q << (lz_q + 4'd1);
    sub_exp  = FP_BIAS_DELTA - {4'b0, lz_q};
  end

  // Leading-zero count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lz_q <= '0;
    end else begin
      lz_q <= lz_d;
    end
  end
`endif

  // Stage 1 captures the raw fields and class of the incoming sample
  always_comb begin
    s1_valid_d = s1_valid_q;
    sign_d     = sign_q;
    cls_d      = cls_q;
    exp_d      = exp_q;
    man_d      = man_q;
    if (advance) begin
      s1_valid_d = in_valid;
      sign_d     = in_h.sign;
      cls_d      = in_cls;
      exp_d      = in_h.exp;
      man_d      = in_h.man;
    end
  end

  // Build the binary32 word from the stage 1 fields
  always_comb begin
    assembled = '0;
    assembled.sign = sign_q;
    case (cls_q)
      ZERO: begin
        assembled.exp  = '0;
        assembled.frac = '0;
      end
      SUBNORM: begin
`ifdef HALF2SINGLE_SUBNORM_EN
        assembled.exp  = sub_exp;
        assembled.frac = {sub_frac, 13'b0};
`else
        assembled.exp  = '0;
        assembled.frac = '0;
`endif
      end
      NORMAL: begin
        assembled.exp  = {3'b0, exp_q} + FP_BIAS_DELTA;
        assembled.frac = {man_q, 13'b0};
      end
      INF: begin
        assembled.exp  = 8'hFF;
        assembled.frac = '0;
      end
      NAN: begin
        assembled.exp  = 8'hFF;
        assembled.frac = {man_q | 10'h200, 13'b0};
      end
      default: begin
        assembled.exp  = '0;
        assembled.frac = '0;
      end
    endcase
  end

  // Stage 2 holds the assembled result and only moves when the pipe advances
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = assembled;
      end
    end
  end

  // Saturating counters; a clear wins over an increment in the same cycle
  always_comb begin
    cnt_sub_d = cnt_sub_q;
    cnt_nan_d = cnt_nan_q;
    if (clr_stats) begin
      cnt_sub_d = '0;
      cnt_nan_d = '0;
    end else if (accept) begin
      if (in_cls == SUBNORM && cnt_sub_q != '1) begin
        cnt_sub_d = cnt_sub_q + 1'b1;
      end
      if (in_cls == NAN && cnt_nan_q != '1) begin
        cnt_nan_d = cnt_nan_q + 1'b1;
      end
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      sign_q      <= 1'b0;
      cls_q       <= ZERO;
      exp_q       <= '0;
      man_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_sub_q   <= '0;
      cnt_nan_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sign_q      <= sign_d;
      cls_q       <= cls_d;
      exp_q       <= exp_d;
      man_q       <= man_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_sub_q   <= cnt_sub_d;
      cnt_nan_q   <= cnt_nan_d;
    end
  end

endmodule

// File: tb/tb_half2single_stream.sv
// Self-checking bench for half2single_stream: directed vector table, stall,
// saturation and reset sequences, then randomized traffic against a model.
// Follows HALF2SINGLE_SUBNORM_EN for the expected subnormal results.
module tb_half2single_stream;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clr_stats;

  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic [15:0] cnt_sub_a, cnt_nan_a;

  logic        in_ready_b, out_valid_b;
  logic [31:0] out_data_b;
  logic [1:0]  cnt_sub_b, cnt_nan_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_queue[$];
  logic        hold_pending = 1'b0;
  logic [31:0] held_data = '0;
  logic        last_acc = 1'b0;
  logic        obs_valid = 1'b0;
  logic [31:0] obs_data = '0;
  logic        obs_ready = 1'b0;
  int          m_sub16 = 0, m_nan16 = 0, m_sub2 = 0, m_nan2 = 0;

  half2single_stream #(.CNT_W(16)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_a),
    .in_data     (in_data),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready),
    .out_data    (out_data_a),
    .clr_stats   (clr_stats),
    .cnt_subnorm (cnt_sub_a),
    .cnt_nan     (cnt_nan_a)
  );

  half2single_stream #(.CNT_W(2)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_b),
    .in_data     (in_data),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready),
    .out_data    (out_data_b),
    .clr_stats   (clr_stats),
    .cnt_subnorm (cnt_sub_b),
    .cnt_nan     (cnt_nan_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value-level reference: rebias normals, normalize subnormals by repeated doubling
  function automatic logic [31:0] ref_conv(input logic [15:0] h);
    logic       s;
    int         e;
    logic [10:0] mm;
    int         e32;
    s  = h[15];
    e  = int'(h[14:10]);
    mm = {1'b0, h[9:0]};
    if (e == 0) begin
      if (mm == 0) return {s, 31'b0};
`ifdef HALF2SINGLE_SUBNORM_EN
      e32 = 113;
      while (!mm[10]) begin
        mm  = mm << 1;
        e32 = e32 - 1;
      end
      return {s, 8'(e32), mm[9:0], 13'b0};
`else
      return {s, 31'b0};
`endif
    end else if (e == 31) begin
      if (mm == 0) return {s, 8'hFF, 23'b0};
      return {s, 8'hFF, mm[9:0] | 10'h200, 13'b0};
    end
    return {s, 8'(e + 112), mm[9:0], 13'b0};
  endfunction

  function automatic bit is_sub(input logic [15:0] h);
    return (h[14:10] == 5'd0) && (h[9:0] != 10'd0);
  endfunction

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One cycle: drive at negedge, observe, score transfers, then cross the posedge
  task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic r, input logic c,
                                input logic use_tab, input logic [31:0] texp);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_stats = c;
    #1;
    obs_valid = out_valid_a;
    obs_data  = out_data_a;
    obs_ready = in_ready_a;
    if (hold_pending) begin
      check_output("hold_valid", {31'b0, out_valid_a}, 32'd1);
      check_output("hold_data", out_data_a, held_data);
    end
    check_output("in_ready_rule", {31'b0, in_ready_a}, {31'b0, (~out_valid_a) | r});
    if (out_valid_a && r) begin
      if (exp_queue.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got %h expected none", out_data_a);
      end else begin
        check_output("out_data", out_data_a, exp_queue.pop_front());
      end
    end
    hold_pending = out_valid_a && !r;
    held_data    = out_data_a;
    last_acc     = v && in_ready_a;
    if (last_acc) exp_queue.push_back(use_tab ? texp : ref_conv(d));
    if (c) begin
      m_sub16 = 0; m_nan16 = 0; m_sub2 = 0; m_nan2 = 0;
    end else if (last_acc) begin
      if (is_sub(d)) begin
        if (m_sub16 < 65535) m_sub16++;
        if (m_sub2 < 3) m_sub2++;
      end
      if (is_nan(d)) begin
        if (m_nan16 < 65535) m_nan16++;
        if (m_nan2 < 3) m_nan2++;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_counters(input string tag);
    #1;
    check_output({tag, "_cnt_sub_a"}, {16'b0, cnt_sub_a}, 32'(m_sub16));
    check_output({tag, "_cnt_nan_a"}, {16'b0, cnt_nan_a}, 32'(m_nan16));
    check_output({tag, "_cnt_sub_b"}, {30'b0, cnt_sub_b}, 32'(m_sub2));
    check_output({tag, "_cnt_nan_b"}, {30'b0, cnt_nan_b}, 32'(m_nan2));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && exp_queue.size() != 0; i++) idle(1);
    idle(1);
    check_output({tag, "_drain_left"}, 32'(exp_queue.size()), 32'd0);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [15:0] rd;
    logic        rv, rr, rc;
    int          idx;
    int          cyc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;
    clr_stats = 1'b0;

    vecs[0] = '{16'h3C00, 32'h3F800000};
    vecs[1] = '{16'hC000, 32'hC0000000};
`ifdef HALF2SINGLE_SUBNORM_EN
    vecs[2] = '{16'h0001, 32'h33800000};
    vecs[3] = '{16'h03FF, 32'h387FC000};
`else
    vecs[2] = '{16'h0001, 32'h00000000};
    vecs[3] = '{16'h03FF, 32'h00000000};
`endif
    vecs[4] = '{16'hFC00, 32'hFF800000};
    vecs[5] = '{16'h7D00, 32'h7FE00000};
    vecs[6] = '{16'h8000, 32'h80000000};
    vecs[7] = '{16'h7BFF, 32'h477FE000};
    vecs[8] = '{16'h0400, 32'h38800000};

    // Reset state
    #23;
    check_output("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    check_output("rst_out_data", out_data_a, 32'h0);
    check_output("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    check_output("rst_cnt_sub", {16'b0, cnt_sub_a}, 32'd0);
    check_output("rst_cnt_nan", {16'b0, cnt_nan_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table, back to back, with first-sample latency checks
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, vecs[i].din, 1'b1, 1'b0, 1'b1, vecs[i].dout);
      if (i == 1) check_output("latency_cycle1_valid", {31'b0, obs_valid}, 32'd0);
      if (i == 2) check_output("latency_cycle2_valid", {31'b0, obs_valid}, 32'd1);
    end
    drain("table");
    check_counters("table");
    check_output("table_subnorm_is_2", {16'b0, cnt_sub_a}, 32'd2);
    check_output("table_nan_is_1", {16'b0, cnt_nan_a}, 32'd1);

    // Backpressure: 8 incrementing normals with a 3-cycle stall mid-stream
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 40) begin
      rr = !(cyc >= 4 && cyc <= 6);
      apply_stimulus(1'b1, 16'h3C00 + 16'(idx), rr, 1'b0, 1'b0, 32'h0);
      if (!rr) check_output("stall_in_ready_low", {31'b0, obs_ready}, 32'd0);
      if (last_acc) idx++;
      cyc++;
    end
    check_output("bp_all_accepted", 32'(idx), 32'd8);
    drain("bp");

    // Saturation on the 2-bit counter, then clear colliding with an accept
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 16'h7C01 + 16'(i), 1'b1, 1'b0, 1'b0, 32'h0);
    check_counters("sat");
    check_output("sat_nan_b_is_3", {30'b0, cnt_nan_b}, 32'd3);
    apply_stimulus(1'b1, 16'hFE00, 1'b1, 1'b1, 1'b0, 32'h0);
    check_counters("clr");
    check_output("clr_nan_b_is_0", {30'b0, cnt_nan_b}, 32'd0);
    drain("sat");

    // Asynchronous reset with two samples in flight
    apply_stimulus(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 16'h7C10, 1'b1, 1'b0, 1'b0, 32'h0);
    #3;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_output("midrst_out_valid", {31'b0, out_valid_a}, 32'd0);
    check_output("midrst_cnt_sub", {16'b0, cnt_sub_a}, 32'd0);
    check_output("midrst_cnt_nan", {16'b0, cnt_nan_a}, 32'd0);
    exp_queue.delete();
    hold_pending = 1'b0;
    m_sub16 = 0; m_nan16 = 0; m_sub2 = 0; m_nan2 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b1, 16'h4200, 1'b1, 1'b0, 1'b1, 32'h40400000);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("postrst_cycle1_valid", {31'b0, obs_valid}, 32'd0);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("postrst_cycle2_valid", {31'b0, obs_valid}, 32'd1);
    check_output("postrst_queue_empty", 32'(exp_queue.size()), 32'd0);

    // Randomized traffic with random stalls and occasional clears
    rd = 16'h0;
    rv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(rv && !last_acc)) begin
        rd = 16'($urandom);
        case ($urandom_range(0, 3))
          0: rd[14:10] = 5'd0;
          1: rd[14:10] = 5'd31;
          default: ;
        endcase
        if ($urandom_range(0, 7) == 0) rd[9:0] = 10'd0;
      end
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 63) == 0);
      apply_stimulus(rv, rd, rr, rc, 1'b0, 32'h0);
    end
    drain("rand");
    check_counters("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
